aes_shift_rows_pipe: RTL and testbench
======================================

AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4, meaning state column count; legal values 4, 6, 8 (Rijndael block widths 128/192/256); any other value SHALL fail elaboration.
REQ-002 Derived constant W = 32*NB SHALL define the state width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream asserts that in_state and in_inv are valid.
REQ-006 in_ready  output  1  block accepts a transfer this cycle.
REQ-007 in_inv  input  1  per-transfer mode: 1 = InvShiftRows, 0 = ShiftRows.
REQ-008 in_state  input  [0:W-1]  input state; byte k = bits [8k:8k+7], column-major, row r of column c = byte 4c+r.
REQ-009 out_valid  output  1  out_state and out_inv hold a result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_state  output  [0:W-1]  permuted state, same byte layout as in_state.
REQ-012 out_inv  output  1  mode bit of the transfer presented on out_state.
REQ-013 busy  output  1  high while any result is held internally.

Function
REQ-014 A transfer SHALL occur on a rising edge where valid and ready are both high, on each side independently.
REQ-015 Row shift offsets SHALL be C0..C3 = 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-016 Inverse mode: out byte (r,c) SHALL equal in byte (r, (c - Cr) mod NB).
REQ-017 Forward mode: out byte (r,c) SHALL equal in byte (r, (c + Cr) mod NB).
REQ-018 Mode SHALL be sampled with the data at input transfer and carried with it; mixed-mode streams SHALL be handled back-to-back without bubbles.
REQ-019 The permutation SHALL be computed before the storage register; latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-020 out_state and out_inv SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-022 Sustained throughput SHALL be one transfer per cycle while out_ready=1.
REQ-023 Simultaneous input and output transfer on a full single stage SHALL replace the held result with the new one in the same edge.
REQ-024 busy SHALL equal out_valid OR (skid entry occupied).
REQ-025 in_valid SHALL be ignored while in_ready=0; no internal state SHALL change from it.

Reset
REQ-026 While rst_n=0 at a rising edge: out_valid=0, out_inv=0, out_state=all zeros, busy=0, skid entry empty.
REQ-027 in_ready SHALL be 0 during reset and 1 on the first cycle after rst_n returns high.
REQ-028 Reset mid-stream SHALL discard all held results without emitting them.

Configuration
REQ-029 Macro AES_SHIFT_ROWS_SKID_EN defined: a second (skid) entry SHALL be added; in_ready SHALL be a register output equal to NOT(skid entry occupied), with no combinational path from out_ready.
REQ-030 With AES_SHIFT_ROWS_SKID_EN: when out_valid=1, out_ready=0 and an input transfer occurs, the result SHALL go to the skid entry and in_ready SHALL drop next cycle; the skid entry SHALL move to output on the next out_ready=1 edge.
REQ-031 Macro not defined: single stage only; in_ready SHALL equal (NOT out_valid) OR out_ready, combinationally.
REQ-032 Functional results and ordering SHALL be identical in both builds; only in_ready timing differs.

Verification
REQ-033 NB=4, in_inv=1, in_state bytes 00..0F, out_ready=1 -> one cycle later out_state = 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, out_inv=1.
REQ-034 NB=4, in_inv=0, same input -> out_state = 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; feeding this back with in_inv=1 -> bytes 00..0F.
REQ-035 NB=8, random states alternating modes, 1000 back-to-back transfers with out_ready=1 -> one result per cycle, all matching the offsets 0,1,3,4 model, forward-then-inverse round-trip equals input.
REQ-036 Random out_ready (50%) and in_valid (70%), both builds -> no loss, duplication or reordering; out_state stable while stalled; skid build in_ready low only when skid occupied.
REQ-037 rst_n driven low with two results held (skid build), then released -> no result emitted, out_valid=0, busy=0, in_ready=1 on the first cycle after release.
REQ-038 Elaborate with NB=5 -> elaboration error.

Source files
------------

// File: rtl/aes_shift_rows_if.sv
// Handshake bundle for aes_shift_rows_pipe: input transfer side, output result side and busy.
interface aes_shift_rows_if #(
   parameter int unsigned NB = 4
) ();
   localparam int unsigned W = 32 * NB;

   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [0:W-1] in_state;
   logic         out_valid;
   logic         out_ready;
   logic         out_inv;
   logic [0:W-1] out_state;
   logic         busy;

   modport slave (
      input  in_valid, in_inv, in_state, out_ready,
      output in_ready, out_valid, out_inv, out_state, busy
   );

   modport master (
      output in_valid, in_inv, in_state, out_ready,
      input  in_ready, out_valid, out_inv, out_state, busy
   );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Rijndael (Inv)ShiftRows with one registered output stage; define AES_SHIFT_ROWS_SKID_EN
// to add a skid entry so that in_ready is a pure register output.
module aes_shift_rows_pipe #(
   parameter int unsigned NB = 4
) (
   input logic            clk,
   input logic            rst_n,
   aes_shift_rows_if.slave bus
);
   localparam int unsigned W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end

   // Row offsets C0..C3: rows 2 and 3 shift one extra column for 256-bit blocks
   function automatic int unsigned row_off(input int unsigned r);
      return (NB == 8 && r >= 2) ? r + 1 : r;
   endfunction

   logic [0:W-1] fwd_c;
   logic [0:W-1] inv_c;
   logic [0:W-1] perm_c;
   logic         in_fire_c;
   logic         out_fire_c;

   logic         out_valid_q, out_valid_d;
   logic         out_inv_q,   out_inv_d;
   logic [0:W-1] out_state_q, out_state_d;

   // Both permutations use constant byte indices; the mode bit only selects between them
   always_comb begin : p_perm
      fwd_c = '0;
      inv_c = '0;
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            fwd_c[8*(4*c+r) +: 8] = bus.in_state[8*(4*((c + row_off(r)) % NB) + r) +: 8];
            inv_c[8*(4*c+r) +: 8] = bus.in_state[8*(4*((c + NB - row_off(r)) % NB) + r) +: 8];
         end
      end
      perm_c = bus.in_inv ? inv_c : fwd_c;
   end

   assign in_fire_c  = bus.in_valid & bus.in_ready;
   assign out_fire_c = out_valid_q & bus.out_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_inv   = out_inv_q;
   assign bus.out_state = out_state_q;

`ifdef AES_SHIFT_ROWS_SKID_EN
   logic         skid_valid_q, skid_valid_d;
   logic         skid_inv_q,   skid_inv_d;
   logic [0:W-1] skid_state_q, skid_state_d;
   logic         in_ready_q,   in_ready_d;

   assign bus.in_ready = in_ready_q;
   assign bus.busy     = out_valid_q | skid_valid_q;

   // in_ready is only ever high with the skid entry empty, so a stalled accept lands there
   always_comb begin : p_next
      out_valid_d  = out_valid_q;
      out_inv_d    = out_inv_q;
      out_state_d  = out_state_q;
      skid_valid_d = skid_valid_q;
      skid_inv_d   = skid_inv_q;
      skid_state_d = skid_state_q;
      if (out_fire_c) begin
         if (skid_valid_q) begin
            out_inv_d    = skid_inv_q;
            out_state_d  = skid_state_q;
            skid_valid_d = 1'b0;
         end else if (in_fire_c) begin
            out_inv_d    = bus.in_inv;
            out_state_d  = perm_c;
         end else begin
            out_valid_d  = 1'b0;
         end
      end else if (in_fire_c) begin
         if (out_valid_q) begin
            skid_valid_d = 1'b1;
            skid_inv_d   = bus.in_inv;
            skid_state_d = perm_c;
         end else begin
            out_valid_d  = 1'b1;
            out_inv_d    = bus.in_inv;
            out_state_d  = perm_c;
         end
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin : p_regs
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_inv_q    <= 1'b0;
         out_state_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_inv_q   <= 1'b0;
         skid_state_q <= '0;
         in_ready_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_inv_q    <= out_inv_d;
         out_state_q  <= out_state_d;
         skid_valid_q <= skid_valid_d;
         skid_inv_q   <= skid_inv_d;
         skid_state_q <= skid_state_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   logic run_q, run_d;

   // run_q holds in_ready low through reset and for the cycle in which rst_n is released
   assign bus.in_ready = run_q & (~out_valid_q | bus.out_ready);
   assign bus.busy     = out_valid_q;

   always_comb begin : p_next
      run_d       = 1'b1;
      out_valid_d = out_valid_q;
      out_inv_d   = out_inv_q;
      out_state_d = out_state_q;
      if (in_fire_c) begin
         out_valid_d = 1'b1;
         out_inv_d   = bus.in_inv;
         out_state_d = perm_c;
      end else if (out_fire_c) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin : p_regs
      if (!rst_n) begin
         run_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_inv_q   <= 1'b0;
         out_state_q <= '0;
      end else begin
         run_q       <= run_d;
         out_valid_q <= out_valid_d;
         out_inv_q   <= out_inv_d;
         out_state_q <= out_state_d;
      end
   end
`endif
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and randomized-handshake bench for aes_shift_rows_pipe (NB=4 and NB=8 instances);
// skid-specific expectations follow AES_SHIFT_ROWS_SKID_EN.
module tb_aes_shift_rows_pipe;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   aes_shift_rows_if #(.NB(4)) b4 ();
   aes_shift_rows_if #(.NB(8)) b8 ();

   aes_shift_rows_pipe #(.NB(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   aes_shift_rows_pipe #(.NB(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: rotate each row of the column-major state by its offset
   function automatic logic [0:255] shift_model(input logic [0:255] s, input bit inv, input int nb);
      logic [0:255] o;
      int off [4];
      int src;
      o = '0;
      if (nb == 8) off = '{0, 1, 3, 4};
      else         off = '{0, 1, 2, 3};
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
            o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [0:127] model4(input logic [0:127] s, input bit inv);
      logic [0:255] m;
      m = shift_model({s, 128'b0}, inv, 4);
      return m[0:127];
   endfunction

   initial begin : stim
      logic [0:127] seq, inv_exp, fwd_exp, st_a, st_b, st_c, cur, prev_state;
      logic [0:255] s8, exp8, x8, y8;
      logic [128:0] exp_q [$];
      logic [128:0] front;
      bit           exp_inv8, cur_inv, prev_inv, pend, stalled, in_fire, out_fire;
      int           held;

      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      b4.in_valid = 1'b0; b4.in_inv = 1'b0; b4.in_state = '0; b4.out_ready = 1'b0;
      b8.in_valid = 1'b0; b8.in_inv = 1'b0; b8.in_state = '0; b8.out_ready = 1'b0;
      for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k);
      inv_exp = 128'h000D0A07_04010E0B_0805020F_0C090603;
      fwd_exp = 128'h00050A0F_04090E03_080D0207_0C01060B;
      st_a = 128'h3243F6A8_885A308D_313198A2_E0370734;
      st_b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      st_c = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(b4.out_valid), 256'(0));
      check("rst_out_inv",   256'(b4.out_inv),   256'(0));
      check("rst_out_state", 256'(b4.out_state), 256'(0));
      check("rst_busy",      256'(b4.busy),      256'(0));
      check("rst_in_ready",  256'(b4.in_ready),  256'(0));
      check("rst_in_ready8", 256'(b8.in_ready),  256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready",  256'(b4.in_ready),  256'(1));
      check("post_rst_out_valid", 256'(b4.out_valid), 256'(0));

      // Known-answer vectors, back-to-back, mixed modes
      b4.out_ready = 1'b1; b4.in_valid = 1'b1; b4.in_inv = 1'b1; b4.in_state = seq;
      @(posedge clk); #1;
      check("kat_inv_valid", 256'(b4.out_valid), 256'(1));
      check("kat_inv_state", 256'(b4.out_state), 256'(inv_exp));
      check("kat_inv_mode",  256'(b4.out_inv),   256'(1));
      b4.in_inv = 1'b0;
      @(posedge clk); #1;
      check("kat_fwd_state", 256'(b4.out_state), 256'(fwd_exp));
      check("kat_fwd_mode",  256'(b4.out_inv),   256'(0));
      b4.in_inv = 1'b1; b4.in_state = fwd_exp;
      @(posedge clk); #1;
      check("kat_roundtrip", 256'(b4.out_state), 256'(seq));
      check("kat_rt_mode",   256'(b4.out_inv),   256'(1));
      b4.in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain_valid", 256'(b4.out_valid), 256'(0));
      check("drain_busy",  256'(b4.busy),      256'(0));

      // Stall: hold A, offer B while stalled, then release
      b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_state = st_a;
      @(posedge clk); #1;
      check("stall_a_state", 256'(b4.out_state), 256'(model4(st_a, 1'b0)));
      b4.in_inv = 1'b1; b4.in_state = st_b;
`ifdef AES_SHIFT_ROWS_SKID_EN
      #1;
      check("skid_ready_empty", 256'(b4.in_ready), 256'(1));
      @(posedge clk); #1;
      check("skid_ready_full", 256'(b4.in_ready),  256'(0));
      check("skid_hold_a",     256'(b4.out_state), 256'(model4(st_a, 1'b0)));
      check("skid_busy",       256'(b4.busy),      256'(1));
      b4.in_inv = 1'b0; b4.in_state = st_c;
      @(posedge clk); #1;
      check("skid_hold_a2",    256'(b4.out_state), 256'(model4(st_a, 1'b0)));
      check("skid_ready_full2",256'(b4.in_ready),  256'(0));
      b4.out_ready = 1'b1;
      @(posedge clk); #1;
      check("skid_move_b",     256'(b4.out_state), 256'(model4(st_b, 1'b1)));
      check("skid_move_b_mode",256'(b4.out_inv),   256'(1));
      check("skid_ready_back", 256'(b4.in_ready),  256'(1));
      @(posedge clk); #1;
      check("skid_take_c",     256'(b4.out_state), 256'(model4(st_c, 1'b0)));
      b4.in_valid = 1'b0;
`else
      #1;
      check("stall_ready_low", 256'(b4.in_ready), 256'(0));
      @(posedge clk); #1;
      check("stall_ignore_b",  256'(b4.out_state), 256'(model4(st_a, 1'b0)));
      check("stall_busy",      256'(b4.busy),      256'(1));
      @(posedge clk); #1;
      check("stall_hold_a",    256'(b4.out_state), 256'(model4(st_a, 1'b0)));
      check("stall_hold_mode", 256'(b4.out_inv),   256'(0));
      b4.out_ready = 1'b1;
      #1;
      check("stall_ready_comb", 256'(b4.in_ready), 256'(1));
      @(posedge clk); #1;
      check("replace_b",       256'(b4.out_state), 256'(model4(st_b, 1'b1)));
      check("replace_b_mode",  256'(b4.out_inv),   256'(1));
      b4.in_valid = 1'b0;
`endif
      @(posedge clk); #1;
      check("stall_drain_valid", 256'(b4.out_valid), 256'(0));
      check("stall_drain_busy",  256'(b4.busy),      256'(0));

      // Random in_valid (70%) / out_ready (50%) with an ordered scoreboard
      pend = 1'b0; stalled = 1'b0; cur = '0; cur_inv = 1'b0; prev_state = '0; prev_inv = 1'b0;
      for (int i = 0; i < 420; i++) begin
         if (stalled) begin
            check("rand_stable_state", 256'(b4.out_state), 256'(prev_state));
            check("rand_stable_mode",  256'(b4.out_inv),   256'(prev_inv));
         end
         if (i < 400 && !pend && $urandom_range(9) < 7) begin
            cur = {$urandom, $urandom, $urandom, $urandom};
            cur_inv = 1'($urandom_range(1));
            pend = 1'b1;
         end
         b4.in_valid = pend; b4.in_state = cur; b4.in_inv = cur_inv;
         b4.out_ready = (i < 400) ? 1'($urandom_range(1)) : 1'b1;
         #1;
         held = exp_q.size();
         check("rand_out_valid", 256'(b4.out_valid), 256'(held != 0));
`ifdef AES_SHIFT_ROWS_SKID_EN
         check("rand_in_ready", 256'(b4.in_ready), 256'(held < 2));
`else
         check("rand_in_ready", 256'(b4.in_ready), 256'(held == 0 || b4.out_ready));
`endif
         in_fire  = b4.in_valid && b4.in_ready;
         out_fire = b4.out_valid && b4.out_ready;
         if (out_fire && exp_q.size() != 0) begin
            front = exp_q.pop_front();
            check("rand_order", 256'({b4.out_inv, b4.out_state}), 256'(front));
         end
         if (in_fire) begin
            exp_q.push_back({cur_inv, model4(cur, cur_inv)});
            pend = 1'b0;
         end
         stalled = b4.out_valid && !b4.out_ready;
         prev_state = b4.out_state; prev_inv = b4.out_inv;
         @(posedge clk); #1;
      end
      b4.in_valid = 1'b0;
      check("rand_all_emitted", 256'(exp_q.size()), 256'(0));
      check("rand_end_busy",    256'(b4.busy),      256'(0));

      // Reset with results held discards them
      b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_state = st_a;
      @(posedge clk); #1;
      b4.in_state = st_b;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      check("mid_busy", 256'(b4.busy), 256'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid",    256'(b4.out_valid), 256'(0));
      check("mid_rst_busy",     256'(b4.busy),      256'(0));
      check("mid_rst_state",    256'(b4.out_state), 256'(0));
      check("mid_rst_in_ready", 256'(b4.in_ready),  256'(0));
      rst_n = 1'b1; b4.out_ready = 1'b1;
      @(posedge clk); #1;
      check("mid_rel_in_ready", 256'(b4.in_ready),  256'(1));
      check("mid_rel_valid",    256'(b4.out_valid), 256'(0));
      check("mid_rel_busy",     256'(b4.busy),      256'(0));
      @(posedge clk); #1;
      check("mid_no_emit", 256'(b4.out_valid), 256'(0));

      // NB=8: 1000 back-to-back transfers alternating modes
      b8.out_ready = 1'b1;
      exp8 = '0; exp_inv8 = 1'b0;
      for (int i = 0; i <= 1000; i++) begin
         if (i > 0) begin
            check("nb8_valid", 256'(b8.out_valid), 256'(1));
            check("nb8_state", 256'(b8.out_state), 256'(exp8));
            check("nb8_mode",  256'(b8.out_inv),   256'(exp_inv8));
         end
         if (i < 1000) begin
            s8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b8.in_valid = 1'b1; b8.in_state = s8; b8.in_inv = 1'(i % 2);
            exp8 = shift_model(s8, 1'(i % 2), 8); exp_inv8 = 1'(i % 2);
            check("nb8_in_ready", 256'(b8.in_ready), 256'(1));
         end else begin
            b8.in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("nb8_drain", 256'(b8.out_valid), 256'(0));

      // NB=8 forward then inverse round trip through the DUT
      for (int i = 0; i < 4; i++) begin
         x8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         b8.in_valid = 1'b1; b8.in_inv = 1'b0; b8.in_state = x8;
         @(posedge clk); #1;
         y8 = b8.out_state;
         check("nb8_rt_fwd", 256'(y8), 256'(shift_model(x8, 1'b0, 8)));
         b8.in_inv = 1'b1; b8.in_state = y8;
         @(posedge clk); #1;
         check("nb8_rt_inv", 256'(b8.out_state), 256'(x8));
      end
      b8.in_valid = 1'b0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
